// File: rtl/dds_phase_accumulator.sv
// -----------------------------------------------------------------------------
// dds_phase_accumulator
//
// Phase accumulator for a direct digital synthesizer. A frequency tuning word
// (FTW) is added to the accumulator on every clock while running. The top
// ADDR_WIDTH bits of the accumulator plus a phase offset form the sine ROM
// address. A new FTW/offset pair loaded while running is held in shadow
// registers and only takes effect on the next accumulator carry-out, so the
// frequency change lands at a phase-continuous wrap point.
//
// Ports:
//   CLK           in   clock, all logic on rising edge
//   RESET         in   synchronous reset, active low
//   ENABLE        in   1 = run, 0 = idle with accumulator cleared
//   FTW_IN        in   [ACC_WIDTH-1:0]  tuning word to load
//   PHASE_OFS_IN  in   [ADDR_WIDTH-1:0] phase offset to load
//   LOAD          in   load request (accepted when LOAD_READY=1)
//   LOAD_READY    out  1 in IDLE/RUN, 0 while a staged load is pending
//   ROM_ADDRESS   out  registered sine ROM address
//   ADDR_VALID    out  registered, ROM_ADDRESS is a live sample
//   WRAP          out  registered one-cycle pulse on accumulator carry-out
// -----------------------------------------------------------------------------
module dds_phase_accumulator #(
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic [ACC_WIDTH-1:0]  FTW_IN,
    input  logic [ADDR_WIDTH-1:0] PHASE_OFS_IN,
    input  logic                  LOAD,
    output logic                  LOAD_READY,
    output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
    output logic                  ADDR_VALID,
    output logic                  WRAP
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [ACC_WIDTH-1:0]  acc_q,        acc_d;
    logic [ACC_WIDTH-1:0]  ftw_active_q, ftw_active_d;
    logic [ADDR_WIDTH-1:0] ofs_active_q, ofs_active_d;
    logic [ACC_WIDTH-1:0]  ftw_shadow_q, ftw_shadow_d;
    logic [ADDR_WIDTH-1:0] ofs_shadow_q, ofs_shadow_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q,   rom_addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  wrap_q,       wrap_d;

    logic                  load_accept;
    logic [ACC_WIDTH:0]    acc_sum;   // extra MSB holds the carry-out
    logic [ADDR_WIDTH-1:0] addr_sum;

    assign LOAD_READY  = (state_q != ST_PEND);
    assign load_accept = LOAD && LOAD_READY;

    assign acc_sum  = {1'b0, acc_q} + {1'b0, ftw_active_q};
    // Address is formed from the accumulator value before this edge's update.
    assign addr_sum = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + ofs_active_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        ftw_active_d = ftw_active_q;
        ofs_active_d = ofs_active_q;
        ftw_shadow_d = ftw_shadow_q;
        ofs_shadow_d = ofs_shadow_q;
        rom_addr_d   = rom_addr_q;
        addr_valid_d = 1'b0;
        wrap_d       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (!ENABLE) begin
                    // Dropping to idle: address holds, a coincident load
                    // goes straight to the active registers.
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    if (load_accept) begin
                        ftw_active_d = FTW_IN;
                        ofs_active_d = PHASE_OFS_IN;
                    end
                end else begin
                    acc_d        = acc_sum[ACC_WIDTH-1:0];
                    rom_addr_d   = addr_sum;
                    addr_valid_d = 1'b1;
                    wrap_d       = acc_sum[ACC_WIDTH];
                    if (load_accept) begin
                        ftw_shadow_d = FTW_IN;
                        ofs_shadow_d = PHASE_OFS_IN;
                        state_d      = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!ENABLE) begin
                    // Disable wins over a coincident carry; the staged
                    // values are still committed so the load is not lost.
                    state_d      = ST_IDLE;
                    acc_d        = '0;
                    ftw_active_d = ftw_shadow_q;
                    ofs_active_d = ofs_shadow_q;
                end else begin
                    acc_d        = acc_sum[ACC_WIDTH-1:0];
                    rom_addr_d   = addr_sum;
                    addr_valid_d = 1'b1;
                    wrap_d       = acc_sum[ACC_WIDTH];
                    // Swap at the wrap point; this edge's sum still used
                    // the old tuning word.
                    if (acc_sum[ACC_WIDTH]) begin
                        ftw_active_d = ftw_shadow_q;
                        ofs_active_d = ofs_shadow_q;
                        state_d      = ST_RUN;
                    end
                end
            end
            default: begin
                // IDLE (and any unused encoding recovers through here)
                state_d = ST_IDLE;
                acc_d   = '0;
                if (load_accept) begin
                    ftw_active_d = FTW_IN;
                    ofs_active_d = PHASE_OFS_IN;
                end
                if (ENABLE) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_active_q <= '0;
            ofs_active_q <= '0;
            ftw_shadow_q <= '0;
            ofs_shadow_q <= '0;
            rom_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_active_q <= ftw_active_d;
            ofs_active_q <= ofs_active_d;
            ftw_shadow_q <= ftw_shadow_d;
            ofs_shadow_q <= ofs_shadow_d;
            rom_addr_q   <= rom_addr_d;
            addr_valid_q <= addr_valid_d;
            wrap_q       <= wrap_d;
        end
    end

    assign ROM_ADDRESS = rom_addr_q;
    assign ADDR_VALID  = addr_valid_q;
    assign WRAP        = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dds_phase_accumulator
//
// Directed bench for dds_phase_accumulator with default parameters
// (32-bit accumulator, 12-bit address). Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, i.e. after the edge that
// produced them. Expected values are derived by hand from the step size and
// offset of each scenario.
// -----------------------------------------------------------------------------
module tb_dds_phase_accumulator;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [31:0] FTW_IN;
    logic [11:0] PHASE_OFS_IN;
    logic        LOAD;
    logic        LOAD_READY;
    logic [11:0] ROM_ADDRESS;
    logic        ADDR_VALID;
    logic        WRAP;

    int n_checks = 0;
    int n_fail   = 0;

    dds_phase_accumulator #(
        .ACC_WIDTH (32),
        .ADDR_WIDTH(12)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .FTW_IN      (FTW_IN),
        .PHASE_OFS_IN(PHASE_OFS_IN),
        .LOAD        (LOAD),
        .LOAD_READY  (LOAD_READY),
        .ROM_ADDRESS (ROM_ADDRESS),
        .ADDR_VALID  (ADDR_VALID),
        .WRAP        (WRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check all three registered outputs plus LOAD_READY in one call.
    task automatic check_all(input string tag, input int addr, input int valid,
                             input int wrap, input int ready);
        check({tag, "/addr"},  int'(ROM_ADDRESS), addr);
        check({tag, "/valid"}, int'(ADDR_VALID),  valid);
        check({tag, "/wrap"},  int'(WRAP),        wrap);
        check({tag, "/ready"}, int'(LOAD_READY),  ready);
    endtask

    initial begin
        int wraps;

        // ---------------- reset with random inputs ----------------
        RESET        = 1'b0;
        ENABLE       = 1'b0;
        LOAD         = 1'b0;
        FTW_IN       = '0;
        PHASE_OFS_IN = '0;
        for (int i = 0; i < 2; i++) begin
            ENABLE       = 1'($urandom);
            LOAD         = 1'($urandom);
            FTW_IN       = $urandom;
            PHASE_OFS_IN = 12'($urandom);
            tick();
        end
        check_all("reset", 0, 0, 0, 1);
        $display("reset: addr=%h valid=%b wrap=%b ready=%b", ROM_ADDRESS, ADDR_VALID, WRAP, LOAD_READY);
        RESET  = 1'b1;
        ENABLE = 1'b0;
        LOAD   = 1'b0;
        tick();
        check_all("idle_after_reset", 0, 0, 0, 1);

        // ---------------- ramp: FTW=0x0010_0000, ofs=0 ----------------
        LOAD         = 1'b1;
        FTW_IN       = 32'h0010_0000;
        PHASE_OFS_IN = 12'h000;
        tick();
        LOAD   = 1'b0;
        ENABLE = 1'b1;
        tick();                                   // IDLE -> RUN edge
        check("ramp_first_not_valid", int'(ADDR_VALID), 0);
        wraps = 0;
        for (int i = 0; i <= 4096; i++) begin
            tick();
            check("ramp_addr",  int'(ROM_ADDRESS), i & 'hFFF);
            check("ramp_wrap",  int'(WRAP), (i == 4095) ? 1 : 0);
            check("ramp_valid", int'(ADDR_VALID), 1);
            if (WRAP) wraps++;
        end
        check("ramp_wrap_count", wraps, 1);
        $display("ramp: 4097 samples, wraps=%0d, final addr=%h", wraps, ROM_ADDRESS);

        // ---------------- staged load at address 0x100 ----------------
        for (int i = 0; i < 'h100; i++) tick();
        check("staged_start_addr", int'(ROM_ADDRESS), 'h100);
        LOAD   = 1'b1;
        FTW_IN = 32'h0020_0000;
        tick();
        LOAD = 1'b0;
        check("staged_accept_addr",  int'(ROM_ADDRESS), 'h101);
        check("staged_accept_ready", int'(LOAD_READY), 0);
        for (int a = 'h102; a <= 'hFFF; a++) begin
            tick();
            check("staged_addr",  int'(ROM_ADDRESS), a);
            check("staged_ready", int'(LOAD_READY), (a == 'hFFF) ? 1 : 0);
            check("staged_wrap",  int'(WRAP), (a == 'hFFF) ? 1 : 0);
        end
        tick();
        check_all("staged_new0", 'h000, 1, 0, 1);
        tick();
        check_all("staged_new2", 'h002, 1, 0, 1);
        tick();
        check_all("staged_new4", 'h004, 1, 0, 1);
        $display("staged: swap done, addr=%h ready=%b", ROM_ADDRESS, LOAD_READY);

        // ---------------- disable in RUN with direct load, then offset ----------------
        ENABLE       = 1'b0;
        LOAD         = 1'b1;
        FTW_IN       = 32'h0010_0000;
        PHASE_OFS_IN = 12'h800;
        tick();
        LOAD = 1'b0;
        check_all("run_disable_load", 'h004, 0, 0, 1);
        ENABLE = 1'b1;
        tick();
        check("offset_first_not_valid", int'(ADDR_VALID), 0);
        for (int i = 0; i <= 4096; i++) begin
            tick();
            check("offset_addr", int'(ROM_ADDRESS), ('h800 + i) & 'hFFF);
            check("offset_wrap", int'(WRAP), (i == 4095) ? 1 : 0);
        end
        $display("offset: sequence done, addr=%h", ROM_ADDRESS);

        // ---------------- disable mid-run at 0x123 ----------------
        for (int i = 0; i < 'h923; i++) tick();
        check("disable_at_addr", int'(ROM_ADDRESS), 'h123);
        ENABLE = 1'b0;
        tick();
        check_all("disable_edge", 'h123, 0, 0, 1);
        tick();
        check_all("disable_hold", 'h123, 0, 0, 1);
        ENABLE = 1'b1;
        tick();
        check("reenable_not_valid", int'(ADDR_VALID), 0);
        tick();
        check_all("reenable_restart", 'h800, 1, 0, 1);
        $display("disable: held 0x123, restart addr=%h", ROM_ADDRESS);

        // ---------------- disable while PEND commits the shadow ----------------
        LOAD         = 1'b1;
        FTW_IN       = 32'h0030_0000;
        PHASE_OFS_IN = 12'h010;
        tick();
        LOAD = 1'b0;
        check_all("pend_accept", 'h801, 1, 0, 0);
        ENABLE = 1'b0;
        tick();
        check_all("pend_disable", 'h801, 0, 0, 1);
        ENABLE = 1'b1;
        tick();
        tick();
        check_all("pend_commit0", 'h010, 1, 0, 1);
        tick();
        check_all("pend_commit1", 'h013, 1, 0, 1);
        tick();
        check_all("pend_commit2", 'h016, 1, 0, 1);
        $display("pend_disable: committed step 3 from ofs 0x010, addr=%h", ROM_ADDRESS);

        // ---------------- reset while PEND ----------------
        LOAD         = 1'b1;
        FTW_IN       = 32'h0010_0000;
        PHASE_OFS_IN = 12'h055;
        tick();
        LOAD = 1'b0;
        check_all("rst_pend_accept", 'h019, 1, 0, 0);
        tick();
        check_all("rst_pend_hold", 'h01C, 1, 0, 0);
        RESET = 1'b0;
        LOAD  = 1'b1;
        tick();
        check_all("rst_pend_reset", 'h000, 0, 0, 1);
        RESET  = 1'b1;
        LOAD   = 1'b0;
        ENABLE = 1'b1;
        tick();
        check("rst_pend_not_valid", int'(ADDR_VALID), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("ftw_zero", 'h000, 1, 0, 1);
        end
        $display("reset_in_pend: ftw=0 address held at %h", ROM_ADDRESS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_phase_accumulator.md
DDS_PHASE_ACCUMULATOR -- requirements
Module: dds_phase_accumulator

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: phase accumulator and tuning word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: ROM address width, taken from accumulator MSBs.
REQ-003 SHALL have input CLK, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have input RESET, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have input ENABLE, 1 bit: 1 = run accumulator, 0 = idle with accumulator cleared.
REQ-006 SHALL have input FTW_IN, ACC_WIDTH bits: frequency tuning word to load.
REQ-007 SHALL have input PHASE_OFS_IN, ADDR_WIDTH bits: phase offset added to the address.
REQ-008 SHALL have input LOAD, 1 bit: valid; FTW_IN/PHASE_OFS_IN are accepted on an edge where LOAD=1 and LOAD_READY=1.
REQ-009 SHALL have output LOAD_READY, 1 bit: 1 when a load can be accepted.
REQ-010 SHALL have output ROM_ADDRESS, ADDR_WIDTH bits, registered: address to sine ROM.
REQ-011 SHALL have output ADDR_VALID, 1 bit, registered: ROM_ADDRESS is a live sample.
REQ-012 SHALL have output WRAP, 1 bit, registered: one-cycle pulse on accumulator carry-out.

Function
REQ-013 SHALL implement states IDLE, RUN, PEND; LOAD_READY = 1 in IDLE and RUN, 0 in PEND (decoded from state register).
REQ-014 IDLE: acc <= 0, ADDR_VALID <= 0, WRAP <= 0, ROM_ADDRESS holds; accepted load writes ftw_active/ofs_active directly; ENABLE=1 -> RUN.
REQ-015 RUN/PEND, every edge: acc <= (acc + ftw_active) mod 2^ACC_WIDTH; ROM_ADDRESS <= (acc[MSBs] + ofs_active) mod 2^ADDR_WIDTH using pre-update acc; ADDR_VALID <= 1; WRAP <= carry-out of that sum.
REQ-016 First valid address SHALL equal ofs_active, one edge after the IDLE->RUN edge.
REQ-017 RUN with accepted load: FTW_IN/PHASE_OFS_IN -> shadow registers, -> PEND; active values unchanged.
REQ-018 PEND edge with carry-out: acc takes sum computed with old ftw_active; ftw_active/ofs_active <= shadow; -> RUN; new values used from the following edge.
REQ-019 ENABLE=0 in RUN -> IDLE on that edge, acc <= 0; simultaneous accepted LOAD written directly to active registers.
REQ-020 ENABLE=0 in PEND -> IDLE; shadow copied to active on that edge (load not lost).
REQ-021 ENABLE has priority over carry-triggered swap when both occur on one edge (outcome identical per REQ-020).
REQ-022 FTW of 0 SHALL be legal: address constant at ofs_active, WRAP never asserted.

Reset
REQ-023 On an edge with RESET=0: state=IDLE, acc=0, ftw_active=0, ofs_active=0, shadow=0, ROM_ADDRESS=0, ADDR_VALID=0, WRAP=0; LOAD_READY=1 after the edge.
REQ-024 Reset SHALL override all inputs, including mid-PEND; pending shadow discarded.

Verification
REQ-025 Reset: hold RESET=0 two cycles with random inputs -> ROM_ADDRESS=0x000, ADDR_VALID=0, WRAP=0, LOAD_READY=1.
REQ-026 Ramp: load FTW=0x0010_0000, ofs=0 in IDLE, ENABLE=1 -> ROM_ADDRESS 0x000,0x001,...,0xFFF,0x000; WRAP high on the edge ROM_ADDRESS becomes 0xFFF, once per 4096 cycles.
REQ-027 Offset: FTW=0x0010_0000, ofs=0x800 -> sequence 0x800..0xFFF,0x000..0x7FF, repeating.
REQ-028 Staged load: running at FTW=0x0010_0000, load FTW=0x0020_0000 at address 0x100 -> LOAD_READY=0, step stays 1 through 0xFFF, then 0x000,0x002,0x004; LOAD_READY=1 from the swap edge.
REQ-029 Disable: ENABLE=0 mid-run at address 0x123 -> next edge ADDR_VALID=0, ROM_ADDRESS holds 0x123; re-enable -> restarts at ofs_active.
REQ-030 Reset in PEND: assert RESET=0 while PEND -> all registers per REQ-023; after ENABLE=1 address stays 0x000 (FTW=0).
